sdr_port_arbiter: RTL and testbench
===================================

// Module: sdr_port_arbiter
// PURPOSE
//  Shares the single SDRAM request channel between N requesters: ROM loader, CPU fetch, gfx fetch.
//  Single outstanding transaction.
//  Loader gets absolute priority while a download is active. Otherwise requesters are served round-robin.
//  Sits between the requesters and the SDRAM controller.
//  The downstream side uses toggle req/ack: a transaction is outstanding while sdr_req != sdr_ack.
// PARAMETERS
//  N_REQ       3      number of requesters (2..8)
//  LOADER_IDX  0      requester index that gets download priority
//  TIMEOUT_CYC 1023   watchdog limit in sys_clk cycles; used only with SDR_ARB_WATCHDOG_EN
// PORTS
//  sys_clk        in   1        single clock, all logic on its rising edge
//  reset_n        in   1        asynchronous reset, active-low
//  loader_active  in   1        download in progress (ioctl_downl)
//  rq_req         in   N_REQ    level request per requester
//  rq_we          in   N_REQ    1 = write, 0 = read
//  rq_addr        in   N_REQ*25 flattened; requester i is bits [25i+24:25i]
//  rq_wdata       in   N_REQ*16 flattened write data
//  rq_be          in   N_REQ*2  flattened byte enables
//  rq_ack         out  N_REQ    one-cycle completion pulse per requester
//  rq_rdata       out  16       read data, valid in the rq_ack cycle
//  sdr_req        out  1        toggle request to the SDRAM controller
//  sdr_we/sdr_addr/sdr_data/sdr_be  out  1/25/16/2  registered command fields
//  sdr_ack        in   1        toggle ack from the SDRAM controller (same clock domain)
//  sdr_rdata      in   16       read data, valid when the ack toggles
//  grant_id       out  3        index of the current or last granted requester
//  busy           out  1        high while a transaction is outstanding
//  timeout_err    out  1        sticky watchdog flag
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - every output is 0, including sdr_req, rq_ack, grant_id and timeout_err
//   - state=IDLE, rr_ptr=N_REQ-1
//   - the SDRAM controller must be reset together with this block, so that sdr_ack=0 after reset
//  Eligibility: requester i is eligible when rq_req[i]=1. While loader_active=1, only LOADER_IDX is eligible.
//  IDLE: if any requester is eligible:
//   - choose the winner. If loader_active and the loader requests, the loader wins.
//     Otherwise choose the first eligible index scanning rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
//   - in the same edge: register addr/data/be/we, set grant_id, toggle sdr_req, set busy=1, go to WAIT
//   - latency: sdr_req toggles 1 cycle after rq_req is first sampled high
//  WAIT: when sdr_ack == sdr_req:
//   - rq_rdata <= sdr_rdata
//   - pulse rq_ack[grant_id] for exactly 1 cycle
//   - rr_ptr <= grant_id, busy <= 0, go to DONE
//  DONE: one idle cycle, then IDLE.
//   - this lets the requester drop rq_req or present its next command
//   - back-to-back throughput: 1 transaction per (ack latency + 3) cycles
//  rq_req deasserted during WAIT: the transaction still completes and rq_ack still pulses.
//  rq_req deasserted before the grant: that requester is not served.
//  loader_active rising during WAIT: the in-flight transaction completes normally; masking applies from the next IDLE.
//  Address and width rules: addresses pass through unmodified; no arithmetic on the data path.
//  The 1-bit toggle wraps naturally; the parity comparison is the only completion test.
//  Reset mid-transaction aborts it. No rq_ack is issued.
// CONFIGURATION
//  SDR_ARB_WATCHDOG_EN defined:
//   - a 10+ bit counter runs in WAIT and clears on entry to WAIT
//   - reaching TIMEOUT_CYC forces completion:
//     timeout_err <= 1 (sticky until reset), rq_rdata <= 16'hDEAD, rq_ack pulses,
//     sdr_req <= sdr_ack to resynchronise the toggle pair, go to DONE
//  SDR_ARB_WATCHDOG_EN undefined:
//   - no counter; WAIT holds indefinitely
//   - timeout_err is tied to 0
// STRUCTURE
//  xain_pkg gains:
//   - SDR_AW=25, SDR_DW=16
//   - typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT, ARB_DONE} sdr_arb_state_t
//   - typedef struct packed {we, addr, data, be} sdr_cmd_t
//  Sub-module rr_picker (N_REQ, req vector, rr_ptr -> onehot + index):
//   - purely combinational rotating-priority encoder
//   - reusable for other shared ports
//  Top-level module: state register, command register, toggle pair, watchdog.
// TESTING
//  1. Reset, then rq_req[1]=1 with addr 0x000100, we=0 -> sdr_req toggles at +1 cycle; sdr_addr=0x000100.
//     Model acks after 4 cycles with rdata 0xBEEF -> rq_ack[1] pulses once, rq_rdata=0xBEEF.
//  2. All 3 requesters held high, loader_active=0 -> grants follow 0,1,2,0,1,2. Each rq_ack is exactly 1 cycle wide.
//  3. loader_active=1 with req[0..2] all high -> only index 0 is granted for 20 transactions.
//     Drop loader_active -> index 1 is granted next.
//  4. loader_active rises while index 2 is in WAIT -> index 2 still gets its rq_ack. The next grant is 0.
//  5. Assert reset_n=0 in WAIT -> sdr_req=0, busy=0, no rq_ack. After release, a new request is served cleanly.
//  6. With SDR_ARB_WATCHDOG_EN, the model never acks -> after TIMEOUT_CYC: timeout_err=1, rq_rdata=0xDEAD,
//     sdr_req==sdr_ack. The next transaction completes normally.

Source files
------------

// File: rtl/xain_pkg.sv
// rtl/xain_pkg.sv - shared SDRAM port types: bus widths, arbiter states, command record
package xain_pkg;

  localparam int SDR_AW = 25;
  localparam int SDR_DW = 16;

  // Read data returned to a requester whose transaction was forced complete
  localparam logic [SDR_DW-1:0] SDR_TIMEOUT_RDATA = 16'hDEAD;

  typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT, ARB_DONE} sdr_arb_state_t;

  typedef struct packed {
    logic              we;
    logic [SDR_AW-1:0] addr;
    logic [SDR_DW-1:0] data;
    logic [1:0]        be;
  } sdr_cmd_t;

endpackage

// File: rtl/sdr_port_arbiter_rr_picker.sv
// rtl/sdr_port_arbiter_rr_picker.sv - combinational rotating-priority encoder
// Scans ptr+1, ptr+2, ... modulo N_REQ and returns the first set request as onehot and index.
module rr_picker #(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [2:0]       index
);

  logic found;
  int   idx;

  always_comb begin
    onehot = '0;
    index  = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found       = 1'b1;
        onehot[idx] = 1'b1;
        index       = idx[2:0];
      end
    end
  end

endmodule

// File: rtl/sdr_port_arbiter.sv
// rtl/sdr_port_arbiter.sv - shares one toggle req/ack SDRAM channel among N_REQ requesters
// Optional watchdog forcing completion of a stuck transaction: SDR_ARB_WATCHDOG_EN.
module sdr_port_arbiter
  import xain_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int LOADER_IDX  = 0,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                    sys_clk,
  input  logic                    reset_n,
  input  logic                    loader_active,
  input  logic [N_REQ-1:0]        rq_req,
  input  logic [N_REQ-1:0]        rq_we,
  input  logic [N_REQ*SDR_AW-1:0] rq_addr,
  input  logic [N_REQ*SDR_DW-1:0] rq_wdata,
  input  logic [N_REQ*2-1:0]      rq_be,
  output logic [N_REQ-1:0]        rq_ack,
  output logic [SDR_DW-1:0]       rq_rdata,
  output logic                    sdr_req,
  output logic                    sdr_we,
  output logic [SDR_AW-1:0]       sdr_addr,
  output logic [SDR_DW-1:0]       sdr_data,
  output logic [1:0]              sdr_be,
  input  logic                    sdr_ack,
  input  logic [SDR_DW-1:0]       sdr_rdata,
  output logic [2:0]              grant_id,
  output logic                    busy,
  output logic                    timeout_err
);

  sdr_arb_state_t   state_q, state_d;
  logic [2:0]       rr_ptr;
  sdr_cmd_t         cmd_q, sel_cmd;
  logic [N_REQ-1:0] loader_mask, eligible, pick_onehot;
  logic [2:0]       pick_idx;
  logic             any_elig, complete, timed_out, finish;

  assign loader_mask = {{(N_REQ-1){1'b0}}, 1'b1} << LOADER_IDX;
  assign eligible    = loader_active ? (rq_req & loader_mask) : rq_req;
  assign any_elig    = |eligible;

  // With only the loader eligible during a download, the picker's answer is the loader itself.
  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req    (eligible),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .index  (pick_idx)
  );

  always_comb begin
    sel_cmd = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_onehot[i]) begin
        sel_cmd.we   = sel_cmd.we   | rq_we[i];
        sel_cmd.addr = sel_cmd.addr | rq_addr[i*SDR_AW +: SDR_AW];
        sel_cmd.data = sel_cmd.data | rq_wdata[i*SDR_DW +: SDR_DW];
        sel_cmd.be   = sel_cmd.be   | rq_be[i*2 +: 2];
      end
    end
  end

  assign complete = (state_q == ARB_WAIT) && (sdr_ack == sdr_req);

`ifdef SDR_ARB_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT_CYC >= 1024) ? $clog2(TIMEOUT_CYC + 1) : 10;
  logic [WD_W-1:0] wd_cnt;

  assign timed_out = (state_q == ARB_WAIT) && !complete && (wd_cnt == WD_W'(TIMEOUT_CYC));

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_q == ARB_IDLE)
        wd_cnt <= '0;
      else if (state_q == ARB_WAIT && !finish)
        wd_cnt <= wd_cnt + 1'b1;
      if (timed_out)
        timeout_err <= 1'b1;
    end
  end
`else
  assign timed_out   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign finish = complete || timed_out;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state_q <= ARB_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (any_elig) state_d = ARB_WAIT;
      ARB_WAIT: if (finish)   state_d = ARB_DONE;
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q    <= '0;
      grant_id <= '0;
      sdr_req  <= 1'b0;
      busy     <= 1'b0;
      rq_ack   <= '0;
      rq_rdata <= '0;
      rr_ptr   <= 3'(N_REQ - 1);
    end else begin
      rq_ack <= '0;
      if (state_q == ARB_IDLE && any_elig) begin
        cmd_q    <= sel_cmd;
        grant_id <= pick_idx;
        sdr_req  <= ~sdr_req;
        busy     <= 1'b1;
      end
      if (finish) begin
        rq_ack   <= {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
        rq_rdata <= timed_out ? SDR_TIMEOUT_RDATA : sdr_rdata;
        rr_ptr   <= grant_id;
        busy     <= 1'b0;
        // Forced completion: realign the toggle pair so the next request starts clean
        if (timed_out)
          sdr_req <= sdr_ack;
      end
    end
  end

  assign sdr_we   = cmd_q.we;
  assign sdr_addr = cmd_q.addr;
  assign sdr_data = cmd_q.data;
  assign sdr_be   = cmd_q.be;

endmodule

// File: tb/tb_sdr_port_arbiter.sv
// tb/tb_sdr_port_arbiter.sv - directed self-checking bench for sdr_port_arbiter
// Watchdog step runs only when SDR_ARB_WATCHDOG_EN is defined.
module tb_sdr_port_arbiter;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        loader_active = 1'b0;
  logic [2:0]  rq_req = '0;
  logic [2:0]  rq_we = '0;
  logic [74:0] rq_addr = '0;
  logic [47:0] rq_wdata = '0;
  logic [5:0]  rq_be = '0;
  logic [2:0]  rq_ack;
  logic [15:0] rq_rdata;
  logic        sdr_req, sdr_we;
  logic [24:0] sdr_addr;
  logic [15:0] sdr_data;
  logic [1:0]  sdr_be;
  logic        sdr_ack = 1'b0;
  logic [15:0] sdr_rdata = '0;
  logic [2:0]  grant_id;
  logic        busy, timeout_err;

  int          total = 0;
  int          bad = 0;
  bit          ack_en = 1'b1;
  int          ack_lat = 4;
  logic [15:0] model_rdata = 16'h0000;
  logic [2:0]  got_ack;
  logic [15:0] got_rd;

  sdr_port_arbiter #(.N_REQ(3), .LOADER_IDX(0), .TIMEOUT_CYC(1023)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .loader_active(loader_active),
    .rq_req(rq_req), .rq_we(rq_we), .rq_addr(rq_addr), .rq_wdata(rq_wdata), .rq_be(rq_be),
    .rq_ack(rq_ack), .rq_rdata(rq_rdata),
    .sdr_req(sdr_req), .sdr_we(sdr_we), .sdr_addr(sdr_addr), .sdr_data(sdr_data), .sdr_be(sdr_be),
    .sdr_ack(sdr_ack), .sdr_rdata(sdr_rdata),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  // SDRAM controller stand-in: toggles ack ack_lat cycles after seeing a new request
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (!reset_n) begin
        sdr_ack = 1'b0;
        cnt = 0;
      end else if (ack_en && sdr_req != sdr_ack) begin
        cnt++;
        if (cnt >= ack_lat) begin
          sdr_rdata = model_rdata;
          sdr_ack = ~sdr_ack;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int bound);
    got_ack = '0;
    got_rd = '0;
    for (int c = 0; c < bound; c++) begin
      @(negedge sys_clk);
      if (rq_ack != 3'b000) begin
        got_ack = rq_ack;
        got_rd = rq_rdata;
        break;
      end
    end
  endtask

  // Waits for the next completion, checks the granted index and that the pulse lasts one cycle
  task automatic expect_ack(input string tag, input int exp_idx, input int bound);
    logic [2:0] exp_oh;
    exp_oh = 3'b001 << exp_idx;
    wait_ack(bound);
    check(tag, {29'd0, got_ack}, {29'd0, exp_oh});
    @(negedge sys_clk);
    check({tag, "_width"}, {29'd0, rq_ack}, 32'd0);
  endtask

  task automatic wait_busy(input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge sys_clk);
      if (busy) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic pulse_reset();
    @(negedge sys_clk);
    reset_n = 1'b0;
    rq_req = '0;
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge sys_clk);
    check("rst_sdr_req", {31'd0, sdr_req}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rq_ack", {29'd0, rq_ack}, 32'd0);
    check("rst_grant_id", {29'd0, grant_id}, 32'd0);
    check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    check("rst_rq_rdata", {16'd0, rq_rdata}, 32'd0);
    check("rst_sdr_addr", {7'd0, sdr_addr}, 32'd0);
    reset_n = 1'b1;

    // Step 1: single read from requester 1
    @(negedge sys_clk);
    model_rdata = 16'hBEEF;
    rq_addr[25 +: 25] = 25'h000100;
    rq_wdata[16 +: 16] = 16'h5A5A;
    rq_be[2 +: 2] = 2'b11;
    rq_we = 3'b000;
    rq_req = 3'b010;
    check("t1_no_toggle_yet", {31'd0, sdr_req}, 32'd0);
    @(negedge sys_clk);
    check("t1_sdr_req", {31'd0, sdr_req}, 32'd1);
    check("t1_sdr_addr", {7'd0, sdr_addr}, 32'h100);
    check("t1_sdr_data", {16'd0, sdr_data}, 32'h5A5A);
    check("t1_sdr_be", {30'd0, sdr_be}, 32'd3);
    check("t1_sdr_we", {31'd0, sdr_we}, 32'd0);
    check("t1_grant", {29'd0, grant_id}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_ack(20);
    check("t1_ack", {29'd0, got_ack}, 32'b010);
    check("t1_rdata", {16'd0, got_rd}, 32'hBEEF);
    check("t1_busy_low", {31'd0, busy}, 32'd0);
    rq_req = 3'b000;
    @(negedge sys_clk);
    check("t1_ack_width", {29'd0, rq_ack}, 32'd0);
    repeat (3) @(negedge sys_clk);
    check("t1_no_second_ack", {29'd0, rq_ack}, 32'd0);

    // Step 2: round robin from reset pointer
    pulse_reset();
    model_rdata = 16'h1111;
    rq_req = 3'b111;
    for (int i = 0; i < 6; i++) expect_ack($sformatf("t2_rr_%0d", i), i % 3, 30);

    // Step 3: loader priority for 20 transactions, then rotation resumes after 0
    loader_active = 1'b1;
    for (int i = 0; i < 20; i++) expect_ack($sformatf("t3_loader_%0d", i), 0, 30);
    loader_active = 1'b0;
    expect_ack("t3_after_loader", 1, 30);

    // Step 4: loader rises while requester 2 is in flight
    rq_req = 3'b100;
    wait_busy("t4_busy");
    check("t4_grant2", {29'd0, grant_id}, 32'd2);
    loader_active = 1'b1;
    rq_req = 3'b111;
    expect_ack("t4_inflight_done", 2, 30);
    expect_ack("t4_next_loader", 0, 30);
    loader_active = 1'b0;

    // Step 5: reset in WAIT aborts, then a clean transaction
    rq_req = 3'b010;
    wait_busy("t5_busy");
    reset_n = 1'b0;
    #1;
    check("t5_rst_sdr_req", {31'd0, sdr_req}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_ack", {29'd0, rq_ack}, 32'd0);
    rq_req = 3'b000;
    repeat (2) @(negedge sys_clk);
    check("t5_rst_ack_held", {29'd0, rq_ack}, 32'd0);
    reset_n = 1'b1;
    model_rdata = 16'h1234;
    rq_req = 3'b001;
    wait_ack(30);
    check("t5_after_ack", {29'd0, got_ack}, 32'b001);
    check("t5_after_rdata", {16'd0, got_rd}, 32'h1234);
    rq_req = 3'b000;
    @(negedge sys_clk);

`ifdef SDR_ARB_WATCHDOG_EN
    // Step 6: watchdog forces completion of an unanswered request
    ack_en = 1'b0;
    rq_req = 3'b100;
    wait_ack(1200);
    check("t6_wd_ack", {29'd0, got_ack}, 32'b100);
    check("t6_wd_rdata", {16'd0, got_rd}, 32'hDEAD);
    check("t6_wd_err", {31'd0, timeout_err}, 32'd1);
    check("t6_wd_resync", {31'd0, sdr_req ^ sdr_ack}, 32'd0);
    ack_en = 1'b1;
    model_rdata = 16'h7777;
    wait_ack(40);
    check("t6_next_ack", {29'd0, got_ack}, 32'b100);
    check("t6_next_rdata", {16'd0, got_rd}, 32'h7777);
    check("t6_err_sticky", {31'd0, timeout_err}, 32'd1);
    rq_req = 3'b000;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
